// File: rtl/cgufdbank.sv
// rtl/cgufdbank.sv - fractional clock-enable divider bank with aligned reload and per-channel gating
// Optional: define CGUFDBANK_CNT_EN to add per-channel pulse counters on pulse_cnt.
module cgufdbank #(
    parameter int           NCH    = 6,
    parameter int           FDW    = 8,
    parameter logic [127:0] PARENT = {16{8'd0}},
    parameter logic [127:0] FD_RST = {16{8'hFF}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clkinen,
    input  logic [NCH*FDW-1:0] fd_in,
    input  logic               fd_load,
    output logic               fd_busy,
    input  logic [NCH-1:0]     gate_req,
    output logic [NCH-1:0]     gate_ack,
    output logic [NCH-1:0]     clken,
    output logic [NCH-1:0]     clken_atparent
`ifdef CGUFDBANK_CNT_EN
    ,
    output logic [NCH*16-1:0]  pulse_cnt
`endif
);

    logic [FDW-1:0]     acc    [NCH];
    logic [FDW-1:0]     fd_act [NCH];
    logic [FDW:0]       sum    [NCH];
    logic [NCH*FDW-1:0] shadow;
    logic [NCH-1:0]     gated;
    logic [NCH-1:0]     pen;
    logic [NCH-1:0]     adv;
    logic               apply;

    // Channels are evaluated in index order so a child sees its parent's
    // enable of the same cycle; parents always have a lower index.
    always_comb begin : chain
        logic [NCH-1:0] pen_v;
        logic [NCH-1:0] ce_v;
        pen_v = '0;
        ce_v  = '0;
        for (int i = 0; i < NCH; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, fd_act[i]} + (FDW+1)'(1);
            if (PARENT[i*8 +: 8] == 8'(i)) begin
                pen_v[i] = clkinen;
            end else begin
                for (int j = 0; j < i; j++) begin
                    if (PARENT[i*8 +: 8] == 8'(j)) begin
                        pen_v[i] = ce_v[j];
                    end
                end
            end
            ce_v[i] = pen_v[i] & ~gated[i] & ~reset & sum[i][FDW];
        end
        pen   = pen_v;
        adv   = pen_v & ~gated & {NCH{~reset}};
        clken = ce_v;
    end

    // Reload lands only on a root-channel pulse so every channel restarts in phase.
    assign apply    = fd_busy & clken[0];
    assign gate_ack = gated;

    always_ff @(posedge clk) begin
        if (reset) begin
            fd_busy        <= 1'b0;
            shadow         <= '0;
            gated          <= '0;
            clken_atparent <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc[i]    <= '0;
                fd_act[i] <= FDW'(FD_RST[i*8 +: 8]);
            end
        end else begin
            gated   <= gate_req;
            fd_busy <= fd_load | (fd_busy & ~clken[0]);
            if (fd_load) begin
                shadow <= fd_in;
            end
            for (int i = 0; i < NCH; i++) begin
                if (pen[i]) begin
                    clken_atparent[i] <= clken[i];
                end
                if (apply) begin
                    acc[i]    <= '0;
                    fd_act[i] <= shadow[i*FDW +: FDW];
                end else if (adv[i]) begin
                    acc[i] <= sum[i][FDW-1:0];
                end
            end
        end
    end

`ifdef CGUFDBANK_CNT_EN
    logic [15:0] cnt [NCH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset || apply) begin
                cnt[i] <= '0;
            end else if (clken[i]) begin
                cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        pulse_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            pulse_cnt[i*16 +: 16] = cnt[i];
        end
    end
`endif

endmodule
